// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter in front of a single-port word memory
module dmem_arbiter #(
  parameter int DEPTH = 2048,
  parameter int IDX_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  input  logic [1:0]       req_we,
  input  logic [31:0]      req_addr0,
  input  logic [31:0]      req_addr1,
  input  logic [31:0]      req_wdata0,
  input  logic [31:0]      req_wdata1,
  output logic [1:0]       req_ready,
  output logic [1:0]       resp_valid,
  input  logic [1:0]       resp_ready,
  output logic [31:0]      resp_rdata,
  output logic             resp_err,
  output logic [IDX_W-1:0] mem_idx,
  output logic             mem_we,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAPT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_grant_q, last_grant_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic        winner;
  logic [31:0] win_addr;
  logic [31:0] win_wdata;
  logic        win_we;
  logic        misaligned;
  logic        out_of_range;
  logic        addr_err;
  logic        accept;

  // Round-robin pick: a lone requester wins, a tie goes to the port not granted last
  always_comb begin
    winner = 1'b0;
    case (req_valid)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_grant_q;
      default: winner = 1'b0;
    endcase
  end

  assign win_addr     = winner ? req_addr1 : req_addr0;
  assign win_wdata    = winner ? req_wdata1 : req_wdata0;
  assign win_we       = req_we[winner];
  assign misaligned   = |win_addr[1:0];
  assign out_of_range = win_addr[31:2] >= DEPTH_W;
  assign addr_err     = misaligned | out_of_range;
  // Reset is gated in so a held request cannot see req_ready while rst is high
  assign accept       = (state_q == IDLE) && (|req_valid) && !rst;

  // Next-state and next-register values for the IDLE -> CAPT -> RESP transaction
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    err_d        = err_q;
    rdata_d      = rdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d      = CAPT;
          owner_d      = winner;
          last_grant_d = winner;
          we_d         = win_we;
          err_d        = addr_err;
        end
      end
      CAPT: begin
        // Writes and rejected accesses report zero data rather than stale memory
        rdata_d = (we_q | err_q) ? 32'd0 : mem_rdata;
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready[owner_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and transaction registers; reset abandons any access in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
    end
  end

  // Handshake and memory drive; memory is only touched in the accept cycle
  always_comb begin
    req_ready  = 2'b00;
    resp_valid = 2'b00;
    resp_rdata = 32'd0;
    resp_err   = 1'b0;
    mem_idx    = '0;
    mem_we     = 1'b0;
    mem_wdata  = 32'd0;
    if (accept) begin
      req_ready[winner] = 1'b1;
      mem_idx           = win_addr[IDX_W+1:2];
      mem_wdata         = win_wdata;
      mem_we            = win_we & ~addr_err;
    end
    if ((state_q == RESP) && !rst) begin
      resp_valid[owner_q] = 1'b1;
      resp_rdata          = rdata_q;
      resp_err            = err_q;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter with memory and reference model
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_we;
  logic [31:0] req_addr0, req_addr1, req_wdata0, req_wdata1;
  logic [1:0]  req_ready;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [10:0] mem_idx;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] tb_mem  [0:2047];
  logic [31:0] ref_mem [0:2047];
  logic        m_last;

  typedef struct {
    logic [1:0]  v;
    logic [1:0]  we;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] w0;
    logic [31:0] w1;
    logic        g;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl [10];

  dmem_arbiter #(.DEPTH(2048), .IDX_W(11)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr0  (req_addr0),
    .req_addr1  (req_addr1),
    .req_wdata0 (req_wdata0),
    .req_wdata1 (req_wdata1),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_idx    (mem_idx),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Word memory: synchronous write, one-cycle registered read
  always @(posedge clk) begin
    if (mem_we) tb_mem[mem_idx] <= mem_wdata;
    mem_rdata <= tb_mem[mem_idx];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %h expected %h", tag, nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 2'b00;
    resp_ready = 2'b00;
    @(posedge clk); #1;
    check("reset", "req_ready", 32'(req_ready), 32'd0);
    check("reset", "resp_valid", 32'(resp_valid), 32'd0);
    check("reset", "mem_we", 32'(mem_we), 32'd0);
    rst = 1'b0;
    m_last = 1'b1;
  endtask

  // One full transaction; called just after a posedge with the DUT in IDLE
  task automatic do_txn(input string tag, input logic [1:0] v, input logic [1:0] we,
                        input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] w0, input logic [31:0] w1,
                        input logic eg, input logic eerr, input logic [31:0] erd, input int dly);
    logic [31:0] a;
    logic [31:0] w;
    logic [1:0]  oh;
    logic        exp_we;
    a = eg ? a1 : a0;
    w = eg ? w1 : w0;
    oh = eg ? 2'b10 : 2'b01;
    exp_we = we[eg] & ~eerr;
    req_valid = v; req_we = we;
    req_addr0 = a0; req_addr1 = a1; req_wdata0 = w0; req_wdata1 = w1;
    @(negedge clk);
    check(tag, "req_ready", 32'(req_ready), 32'(oh));
    check(tag, "mem_we", 32'(mem_we), 32'(exp_we));
    check(tag, "mem_idx", 32'(mem_idx), 32'(a[12:2]));
    if (exp_we) check(tag, "mem_wdata", mem_wdata, w);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    check(tag, "capt_resp_valid", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    for (int d = 0; d <= dly; d++) begin
      resp_ready = (d == dly) ? oh : ~oh;
      @(negedge clk);
      check(tag, "resp_valid", 32'(resp_valid), 32'(oh));
      check(tag, "resp_rdata", resp_rdata, erd);
      check(tag, "resp_err", 32'(resp_err), 32'(eerr));
      @(posedge clk); #1;
    end
    resp_ready = 2'b00;
    if (exp_we) ref_mem[a[12:2]] = w;
    m_last = eg;
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
    if (r == 1) return 32'($urandom_range(2048, 100000)) << 2;
    if (r == 2) return 32'h1FFC;
    return 32'($urandom_range(0, 63)) << 2;
  endfunction

  initial begin
    logic [1:0]  v, we;
    logic [31:0] a0, a1, w0, w1, a, rd;
    logic        g, e;
    logic        grants [4];
    logic [3:0]  fair_exp;
    int          ng;

    tbl[0] = '{v:2'b01, we:2'b01, a0:32'h10,   a1:32'h0,    w0:32'hDEADBEEF, w1:32'h0,        g:1'b0, err:1'b0, rdata:32'h0};
    tbl[1] = '{v:2'b01, we:2'b00, a0:32'h10,   a1:32'h0,    w0:32'h0,        w1:32'h0,        g:1'b0, err:1'b0, rdata:32'hDEADBEEF};
    tbl[2] = '{v:2'b11, we:2'b00, a0:32'h10,   a1:32'h10,   w0:32'h0,        w1:32'h0,        g:1'b1, err:1'b0, rdata:32'hDEADBEEF};
    tbl[3] = '{v:2'b01, we:2'b00, a0:32'h1002, a1:32'h0,    w0:32'h0,        w1:32'h0,        g:1'b0, err:1'b1, rdata:32'h0};
    tbl[4] = '{v:2'b10, we:2'b10, a0:32'h0,    a1:32'h2000, w0:32'h0,        w1:32'h12345678, g:1'b1, err:1'b1, rdata:32'h0};
    tbl[5] = '{v:2'b01, we:2'b01, a0:32'h1FFC, a1:32'h0,    w0:32'hCAFEF00D, w1:32'h0,        g:1'b0, err:1'b0, rdata:32'h0};
    tbl[6] = '{v:2'b01, we:2'b00, a0:32'h1FFC, a1:32'h0,    w0:32'h0,        w1:32'h0,        g:1'b0, err:1'b0, rdata:32'hCAFEF00D};
    tbl[7] = '{v:2'b10, we:2'b00, a0:32'h0,    a1:32'h1FFC, w0:32'h0,        w1:32'h0,        g:1'b1, err:1'b0, rdata:32'hCAFEF00D};
    tbl[8] = '{v:2'b10, we:2'b10, a0:32'h0,    a1:32'h20,   w0:32'h0,        w1:32'hA5A5A5A5, g:1'b1, err:1'b0, rdata:32'h0};
    tbl[9] = '{v:2'b11, we:2'b10, a0:32'h20,   a1:32'h24,   w0:32'h0,        w1:32'h11111111, g:1'b0, err:1'b0, rdata:32'hA5A5A5A5};

    for (int i = 0; i < 2048; i++) begin
      tb_mem[i] = 32'd0;
      ref_mem[i] = 32'd0;
    end
    rst = 1'b1;
    req_valid = 2'b00; req_we = 2'b00; resp_ready = 2'b00;
    req_addr0 = 32'd0; req_addr1 = 32'd0; req_wdata0 = 32'd0; req_wdata1 = 32'd0;
    do_reset();

    // Directed transaction table
    for (int i = 0; i < 10; i++) begin
      do_txn($sformatf("tbl%0d", i), tbl[i].v, tbl[i].we, tbl[i].a0, tbl[i].a1,
             tbl[i].w0, tbl[i].w1, tbl[i].g, tbl[i].err, tbl[i].rdata, i % 3);
    end

    // Both ports load continuously from reset: grants alternate starting with the CPU
    do_reset();
    fair_exp = 4'b1010;
    req_valid = 2'b11; req_we = 2'b00; req_addr0 = 32'h10; req_addr1 = 32'h20; resp_ready = 2'b11;
    ng = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        grants[ng] = req_ready[1];
        ng++;
      end
      @(posedge clk); #1;
    end
    check("fair", "grant_count", 32'(ng), 32'd4);
    for (int k = 0; k < ng; k++) check($sformatf("fair%0d", k), "grant", 32'(grants[k]), 32'(fair_exp[k]));

    // Reset asserted in CAPT after a DMA load accept, with the CPU still requesting
    do_reset();
    req_valid = 2'b10; req_we = 2'b00; req_addr1 = 32'h10;
    @(negedge clk);
    check("rstcapt", "accept", 32'(req_ready), 32'h2);
    @(posedge clk); #1;
    req_valid = 2'b01; req_addr0 = 32'h1FFC;
    #2 rst = 1'b1;
    #1;
    check("rstcapt", "req_ready", 32'(req_ready), 32'd0);
    check("rstcapt", "resp_valid", 32'(resp_valid), 32'd0);
    check("rstcapt", "mem_we", 32'(mem_we), 32'd0);
    check("rstcapt", "mem_idx", 32'(mem_idx), 32'd0);
    check("rstcapt", "mem_wdata", mem_wdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 2'b00; resp_ready = 2'b11; m_last = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("rstcapt", "no_resp", 32'(resp_valid), 32'd0);
      @(posedge clk); #1;
    end
    resp_ready = 2'b00;
    do_txn("postrst", 2'b01, 2'b00, 32'h1FFC, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'hCAFEF00D, 0);

    // DMA response held off for five cycles while the CPU waits
    req_valid = 2'b10; req_we = 2'b00; req_addr1 = 32'h1FFC;
    @(negedge clk);
    check("bp", "accept", 32'(req_ready), 32'h2);
    @(posedge clk); #1;
    req_valid = 2'b01; req_addr0 = 32'h10; resp_ready = 2'b00;
    @(negedge clk);
    check("bp", "capt_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp", "resp_valid", 32'(resp_valid), 32'h2);
      check("bp", "resp_rdata", resp_rdata, 32'hCAFEF00D);
      check("bp", "req_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    resp_ready = 2'b10;
    @(negedge clk);
    check("bp", "resp_valid_rel", 32'(resp_valid), 32'h2);
    @(posedge clk); #1;
    resp_ready = 2'b00;
    @(negedge clk);
    check("bp", "cpu_grant", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    resp_ready = 2'b01;
    @(negedge clk);
    check("bp", "cpu_resp_valid", 32'(resp_valid), 32'h1);
    check("bp", "cpu_resp_rdata", resp_rdata, 32'hDEADBEEF);
    @(posedge clk); #1;
    resp_ready = 2'b00;

    // Randomised traffic against the reference model
    do_reset();
    for (int i = 0; i < 150; i++) begin
      v  = 2'($urandom_range(1, 3));
      we = 2'($urandom_range(0, 3));
      a0 = rand_addr();
      a1 = rand_addr();
      w0 = $urandom;
      w1 = $urandom;
      g  = (v == 2'b11) ? ~m_last : v[1];
      a  = g ? a1 : a0;
      e  = (a[1:0] != 2'b00) || (a[31:2] >= 30'd2048);
      rd = (we[g] || e) ? 32'd0 : ref_mem[a[12:2]];
      do_txn($sformatf("rand%0d", i), v, we, a0, a1, w0, w1, g, e, rd, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port, word-organised data memory between two requesters:
  - port 0: the CPU load/store path;
  - port 1: a debug/loader DMA.
- Round-robin arbitration, valid/ready request and response handshakes.
- Byte-address to word-index conversion and alignment/range checking.
- Sits between the requesters and the memory array; the memory has synchronous write and a one-cycle registered read.

Parameters:
- DEPTH, 2048, number of 32-bit words in the memory.
- IDX_W, 11, word-index width, equal to clog2(DEPTH).

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  2  per-port request valid; bit 0 = CPU, bit 1 = DMA.
- req_we  in  2  per-port write enable (1 = store, 0 = load).
- req_addr0, req_addr1  in  32 each  byte addresses.
- req_wdata0, req_wdata1  in  32 each  store data.
- req_ready  out  2  per-port request accept.
- resp_valid  out  2  per-port response valid.
- resp_ready  in  2  per-port response accept.
- resp_rdata  out  32  load data, shared by both ports, qualified by resp_valid.
- resp_err  out  1  error flag, qualified by resp_valid.
- mem_idx  out  IDX_W  word index to memory.
- mem_we  out  1  memory write strobe.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, valid the cycle after mem_idx is presented.

Behaviour:
- FSM states: IDLE, CAPT, RESP. Registers:
  - owner (1 bit);
  - last_grant (1 bit);
  - we_q;
  - err_q;
  - rdata_q (32).
- Reset (async, any state, mid-transaction included):
  - state=IDLE, last_grant=1, owner=0, rdata_q=0, err_q=0, we_q=0.
  - All outputs 0: req_ready, resp_valid, mem_we, mem_idx, mem_wdata.
  - An in-flight access is abandoned with no response.
  - A write already strobed is not undone.
- IDLE, grant selection:
  - If exactly one req_valid bit is set, that port wins.
  - If both are set, the port != last_grant wins.
  - req_ready[winner]=1 combinationally in the same cycle; the other bit is 0.
  - Accept = req_valid & req_ready at a posedge: owner<=winner, last_grant<=winner, state->CAPT.
  - No valid requests: stay in IDLE, outputs 0.
- Address checks, combinational in IDLE on the winner:
  - misaligned = addr[1:0] != 0;
  - out-of-range = addr[31:2] >= DEPTH;
  - err = misaligned | out-of-range.
- Memory drive in the accept cycle:
  - mem_idx = addr[IDX_W+1:2];
  - mem_wdata = winner wdata;
  - mem_we = winner req_we & ~err;
  - err_q<=err, we_q<=req_we.
  - An erroring write never strobes mem_we. Outside the accept cycle mem_we=0.
- CAPT (one cycle):
  - rdata_q <= (we_q | err_q) ? 0 : mem_rdata.
  - state->RESP.
  - req_ready=0 for both ports.
- RESP:
  - resp_valid[owner]=1; resp_rdata=rdata_q; resp_err=err_q.
  - Hold all of these stable until resp_ready[owner]=1 at a posedge, then state->IDLE.
  - resp_ready of the non-owner port is ignored.
  - req_ready=0 for both ports.
- Timing:
  - Accept at edge T, resp_valid high from T+2.
  - Minimum 3 cycles per transaction; no overlap or pipelining.
- Requests held by a losing port stay pending; the requester must keep valid and payload stable until accepted. A winner is never starved: round-robin guarantees a grant within one transaction.
- A write returns resp_rdata=0, resp_err=err_q.
- Simultaneous request from the owner while in RESP is not accepted until back in IDLE.

Test Plan:
- Reset then CPU store addr=0x10, wdata=0xDEADBEEF; later CPU load addr=0x10:
  - store: mem_we=1 with mem_idx=4 in the accept cycle; resp_valid[0] at accept+2 with rdata=0, err=0;
  - load: resp_rdata=0xDEADBEEF, err=0.
- Both ports request a load every cycle from reset:
  - grants alternate CPU, DMA, CPU, DMA;
  - the first grant goes to the CPU because last_grant resets to 1.
- CPU load with addr=0x1002 (misaligned), then DMA store with addr=0x2000 (word 2048 >= DEPTH):
  - both give resp_err=1 and resp_rdata=0;
  - mem_we stays 0 throughout.
- DMA load with resp_ready[1]=0 held for 5 cycles:
  - resp_valid[1] and resp_rdata stay stable all 5 cycles;
  - req_ready stays 0 even with CPU valid;
  - when resp_ready rises, the CPU is granted in the next IDLE cycle.
- Assert rst for one cycle while in CAPT after a DMA load accept:
  - outputs go to 0 immediately (asynchronous);
  - no resp_valid appears;
  - the next CPU request is accepted normally.
- Last word: CPU store addr=0x1FFC, then load of the same address:
  - mem_idx=2047, err=0, data read back correctly.
